// File: rtl/lynx_kbd_pkg.sv
// Shared types and constants for the PS/2 to Lynx keyboard matrix bridge.
package lynx_kbd_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_F12 = 8'h07;

  localparam int KBD_ROWS = 10;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} kbd_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t kp(input logic [3:0] row, input logic [2:0] col);
    key_pos_t p;
    p.hit = 1'b1;
    p.row = row;
    p.col = col;
    return p;
  endfunction

endpackage

// File: rtl/lynx_keymap_rom.sv
// Combinational lookup from {ext, scan code} to a Lynx matrix cell.
module lynx_keymap_rom
  import lynx_kbd_pkg::*;
(
  input  logic [8:0] code_i,
  output key_pos_t   pos_o
);

  always_comb begin
    pos_o = '0;
    case (code_i)
      // both shift keys share one cell
      9'h012, 9'h059: pos_o = kp(4'd0, 3'd0);
      9'h076: pos_o = kp(4'd0, 3'd1);
      9'h172: pos_o = kp(4'd0, 3'd2);
      9'h175: pos_o = kp(4'd0, 3'd3);
      9'h058: pos_o = kp(4'd0, 3'd4);
      9'h016: pos_o = kp(4'd0, 3'd5);
      9'h026: pos_o = kp(4'd1, 3'd0);
      9'h025: pos_o = kp(4'd1, 3'd1);
      9'h024: pos_o = kp(4'd1, 3'd2);
      9'h022: pos_o = kp(4'd1, 3'd3);
      9'h023: pos_o = kp(4'd1, 3'd4);
      9'h021: pos_o = kp(4'd1, 3'd5);
      9'h01E: pos_o = kp(4'd2, 3'd0);
      9'h01D: pos_o = kp(4'd2, 3'd1);
      9'h01B: pos_o = kp(4'd2, 3'd2);
      9'h01A: pos_o = kp(4'd2, 3'd3);
      9'h015: pos_o = kp(4'd2, 3'd4);
      9'h01C: pos_o = kp(4'd2, 3'd5);
      9'h02E: pos_o = kp(4'd3, 3'd0);
      9'h02D: pos_o = kp(4'd3, 3'd1);
      9'h02B: pos_o = kp(4'd3, 3'd2);
      9'h02A: pos_o = kp(4'd3, 3'd3);
      9'h02C: pos_o = kp(4'd3, 3'd4);
      9'h034: pos_o = kp(4'd3, 3'd5);
      9'h036: pos_o = kp(4'd4, 3'd0);
      9'h035: pos_o = kp(4'd4, 3'd1);
      9'h033: pos_o = kp(4'd4, 3'd2);
      9'h029: pos_o = kp(4'd4, 3'd3);
      9'h031: pos_o = kp(4'd4, 3'd4);
      9'h032: pos_o = kp(4'd4, 3'd5);
      9'h03D: pos_o = kp(4'd5, 3'd0);
      9'h03E: pos_o = kp(4'd5, 3'd1);
      9'h03C: pos_o = kp(4'd5, 3'd2);
      9'h03A: pos_o = kp(4'd5, 3'd3);
      9'h03B: pos_o = kp(4'd5, 3'd4);
      9'h046: pos_o = kp(4'd6, 3'd0);
      9'h043: pos_o = kp(4'd6, 3'd1);
      9'h042: pos_o = kp(4'd6, 3'd2);
      9'h044: pos_o = kp(4'd6, 3'd3);
      9'h041: pos_o = kp(4'd6, 3'd4);
      9'h045: pos_o = kp(4'd7, 3'd0);
      9'h04D: pos_o = kp(4'd7, 3'd1);
      9'h04B: pos_o = kp(4'd7, 3'd2);
      9'h049: pos_o = kp(4'd7, 3'd3);
      9'h04C: pos_o = kp(4'd7, 3'd4);
      9'h04E: pos_o = kp(4'd8, 3'd0);
      9'h054: pos_o = kp(4'd8, 3'd1);
      9'h052: pos_o = kp(4'd8, 3'd2);
      9'h04A: pos_o = kp(4'd8, 3'd3);
      9'h05B: pos_o = kp(4'd8, 3'd4);
      9'h16B: pos_o = kp(4'd8, 3'd5);
      9'h066: pos_o = kp(4'd9, 3'd0);
      9'h05A: pos_o = kp(4'd9, 3'd1);
      9'h174: pos_o = kp(4'd9, 3'd2);
      9'h014: pos_o = kp(4'd9, 3'd3);
      default: pos_o = '0;
    endcase
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 receiver feeding the Lynx key matrix, with F12 host-reset request.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_keymatrix
  import lynx_kbd_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 16384,
  parameter int ROWS     = KBD_ROWS
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic [3:0] row_sel_i,
  output logic [7:0] col_n_o,
  output logic       key_valid_o,
  output logic [7:0] key_code_o,
  output logic       reset_req_o,
  output logic       frame_err_o
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  logic [1:0]          clk_sync_q, data_sync_q;
  logic [FILT_LEN-1:0] clk_hist_q, data_hist_q;
  logic                clk_filt_q, data_filt_q;
  logic                clk_fall;

  kbd_state_t state_q, state_d;
  logic [2:0]      bitcnt_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [TO_W-1:0] to_q;
  logic            timeout;
  logic            stop_good, accept_d, frame_err_d;

  logic            ext_q, brk_q, reset_req_q, key_valid_q, frame_err_q;
  logic [7:0]      key_code_q, col_n_q, row_bits;
  logic [7:0]      matrix_q [ROWS];
  key_pos_t        pos;

  // Filtered level only moves once FILT_LEN synced samples agree.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_hist_q  <= '1;
      data_hist_q <= '1;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_hist_q  <= {clk_hist_q[FILT_LEN-2:0], clk_sync_q[1]};
      data_hist_q <= {data_hist_q[FILT_LEN-2:0], data_sync_q[1]};
      if (&clk_hist_q) clk_filt_q <= 1'b1;
      else if (~|clk_hist_q) clk_filt_q <= 1'b0;
      if (&data_hist_q) data_filt_q <= 1'b1;
      else if (~|data_hist_q) data_filt_q <= 1'b0;
    end
  end

  assign clk_fall = clk_filt_q && (clk_hist_q == '0);
  assign timeout  = (state_q != IDLE) && (to_q == '0) && !clk_fall;

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (clk_fall) begin
      case (state_q)
        IDLE:    if (!data_filt_q) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign stop_good = data_filt_q && (^{shift_q, parity_q});
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign stop_good     = data_filt_q;
`endif

  always_comb begin
    accept_d    = 1'b0;
    frame_err_d = 1'b0;
    if (timeout) begin
      frame_err_d = 1'b1;
    end else if (clk_fall) begin
      case (state_q)
        IDLE: frame_err_d = data_filt_q;
        STOP: begin
          accept_d    = stop_good;
          frame_err_d = !stop_good;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      bitcnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      to_q     <= TO_LOAD;
    end else begin
      if (clk_fall) to_q <= TO_LOAD;
      else if (state_q != IDLE && to_q != '0) to_q <= to_q - 1'b1;
      if (clk_fall) begin
        case (state_q)
          IDLE: bitcnt_q <= '0;
          DATA: begin
            shift_q  <= {data_filt_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
          end
          PARITY:  parity_q <= data_filt_q;
          default: ;
        endcase
      end
    end
  end

  lynx_keymap_rom u_rom (
    .code_i ({ext_q, shift_q}),
    .pos_o  (pos)
  );

  always_comb begin
    row_bits = 8'h00;
    for (int r = 0; r < ROWS; r++)
      if (row_sel_i == 4'(r)) row_bits = matrix_q[r];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      reset_req_q <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      key_code_q  <= '0;
      col_n_q     <= 8'hFF;
      for (int r = 0; r < ROWS; r++) matrix_q[r] <= '0;
    end else begin
      key_valid_q <= accept_d;
      frame_err_q <= frame_err_d;
      col_n_q     <= ~row_bits;
      if (accept_d) begin
        key_code_q <= shift_q;
        if (shift_q == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (shift_q == SC_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (shift_q == SC_F12) reset_req_q <= ~brk_q;
          if (pos.hit)
            for (int r = 0; r < ROWS; r++)
              if (pos.row == 4'(r)) matrix_q[r][pos.col] <= ~brk_q;
        end
      end
    end
  end

  assign col_n_o     = col_n_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign reset_req_o = reset_req_q;
  assign frame_err_o = frame_err_q;

endmodule
